// File: rtl/multichannel_variable_delay_line.sv
// Multi-channel, runtime-configurable delay line.
// Every lane has a MAX_DEPTH-entry shift chain. A depth mux reads entry D-1
// straight from the registers, so the delay is D advances with no extra output stage.
// The active depth D is loaded (and clamped) only on reset or clear.
module multichannel_variable_delay_line #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 3,
  parameter int MAX_DEPTH = 16,
  parameter int DW        = 5
) (
  input  logic                      clk,
  input  logic                      global_rst_n,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic [DW-1:0]             cfg_depth,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      out_valid,
  output logic                      primed,
  output logic [DW-1:0]             fill_count,
  output logic                      cfg_err
);

  localparam int            AW    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

  logic [WIDTH-1:0] sr_q [CHANNELS][MAX_DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic             out_valid_q;
  logic             cfg_err_q, cfg_err_d;
  logic             advance;
  logic [AW-1:0]    rd_sel;

  assign advance = ce && in_valid && global_rst_n && !rst;

  // Clamp the requested depth into 1..MAX_DEPTH and flag any clamping.
  always_comb begin
    depth_d   = cfg_depth;
    cfg_err_d = 1'b0;
    if (cfg_depth == '0) begin
      depth_d   = DW'(1);
      cfg_err_d = 1'b1;
    end else if (cfg_depth > MAX_D) begin
      depth_d   = MAX_D;
      cfg_err_d = 1'b1;
    end
  end

  // The fill counter saturates at the active depth. It never exceeds D, so equality is enough.
  assign fill_d = (fill_q == depth_q) ? fill_q : fill_q + 1'b1;

  // Storage and control: reset/clear > advance > hold. Reset and clear load the same values.
  always_ff @(posedge clk) begin
    if (!global_rst_n || rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        for (int i = 0; i < MAX_DEPTH; i++) begin
          sr_q[k][i] <= '0;
        end
      end
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      depth_q     <= depth_d;
      cfg_err_q   <= cfg_err_d;
    end else if (advance) begin
      for (int k = 0; k < CHANNELS; k++) begin
        sr_q[k][0] <= d[k*WIDTH +: WIDTH];
        for (int i = 1; i < MAX_DEPTH; i++) begin
          sr_q[k][i] <= sr_q[k][i-1];
        end
      end
      fill_q      <= fill_d;
      out_valid_q <= (fill_d == depth_q);
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign rd_sel = AW'(depth_q - 1'b1);

  // Depth mux: each lane presents its entry at depth D-1.
  always_comb begin
    out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      out[k*WIDTH +: WIDTH] = sr_q[k][rd_sel];
    end
  end

  assign out_valid  = out_valid_q;
  assign primed     = (fill_q == depth_q);
  assign fill_count = fill_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: doc/multichannel_variable_delay_line.md
Name: multichannel_variable_delay_line

Overview:
- Multi-channel, runtime-configurable delay line for the streaming datapath (line-buffer / window-alignment use).
- CHANNELS independent data lanes share one control path.
- Delay depth is programmable per run, from 1 to MAX_DEPTH samples.
- Adds valid tracking, a fill counter, a primed flag and configuration error reporting.

Parameters:
- WIDTH, 8: bits per channel sample.
- CHANNELS, 3: number of parallel lanes.
- MAX_DEPTH, 16: maximum storage depth per lane, in samples; minimum 1.
- DW, 5: width of the depth and fill fields; must satisfy 2^DW > MAX_DEPTH.

Ports:
- clk, input, 1: single clock; all logic updates on its rising edge.
- global_rst_n, input, 1: synchronous active-low reset, sampled on rising clk.
- rst, input, 1: synchronous active-high clear; also loads a new depth configuration.
- ce, input, 1: clock enable.
- in_valid, input, 1: d carries a sample this cycle.
- cfg_depth, input, DW: requested delay depth; sampled only on reset or clear.
- d, input, CHANNELS*WIDTH: input samples; lane k occupies bits [k*WIDTH +: WIDTH].
- out, output, CHANNELS*WIDTH: delayed samples, same lane packing as d.
- out_valid, output, 1: out holds a newly produced delayed sample.
- primed, output, 1: delay line is full at the active depth.
- fill_count, output, DW: number of samples held, saturating at the active depth.
- cfg_err, output, 1: sticky flag; last loaded cfg_depth was illegal.

Behaviour:
- Advance = ce && in_valid && global_rst_n && !rst.
- Priority per cycle: global_rst_n low > rst high > advance > hold.
- Reset and clear load identically:
  - every storage element of every lane <= 0;
  - fill_count <= 0;
  - out_valid <= 0.
- Depth load on reset or clear: active depth D <= cfg_depth, clamped.
  - cfg_depth = 0 gives D = 1; cfg_depth > MAX_DEPTH gives D = MAX_DEPTH.
  - cfg_err <= 1 if clamping occurred, else 0.
- cfg_depth is ignored at all other times; a change mid-run has no effect until the next rst or reset.
- rst acts regardless of ce. A cycle with rst and in_valid together is a clear; that d is dropped.
- On an advance, per lane: sr[0] <= d lane, sr[i] <= sr[i-1] for i = 1..MAX_DEPTH-1.
- fill_count <= min(fill_count + 1, D).
- No advance (ce low, or in_valid low): all storage, fill_count and cfg_err hold; out_valid <= 0.
- out lane k = sr[D-1] of lane k, read from registers through a depth mux (no extra register stage).
- After reset, out = 0.
- Latency: the sample written on advance n appears on out in the cycle after advance n+D-1, i.e. a delay of D advances. Idle cycles do not age data.
- primed = (fill_count == D), decoded from registers; 0 after reset.
- out_valid is registered. It is 1 for exactly the cycle after an advance whose updated fill_count == D; otherwise 0.
  - Once primed, every advance produces exactly one out_valid pulse.
- Boundaries:
  - D = 1: out = last advanced sample; out_valid follows every advance by one cycle.
  - D = MAX_DEPTH: the full shift chain is used; the oldest sample drops off the end on each advance.
  - fill_count saturates at D and never wraps.
- Reset or clear mid-run discards all contents; out_valid and primed drop the next cycle.
- Lanes never interact: identical timing, independent data.
- Reset values: out = 0, out_valid = 0, primed = 0, fill_count = 0, cfg_err = (cfg_depth illegal while reset is sampled).

Test Plan:
- D=3, CHANNELS=3: advance samples 0x11/0x22/0x33, then 0x44, then 0x55.
  - First out_valid is the cycle after the 3rd advance, with out = 0x11 on all lanes.
  - fill_count = 3, primed = 1.
  - The 4th advance gives out = 0x22 with out_valid = 1.
- ce gating: after priming at D=3, toggle ce low for 5 cycles while in_valid = 1.
  - out, fill_count and primed are frozen; out_valid = 0 throughout.
  - Output resumes in order once ce returns high.
- Clear mid-fill: after 2 advances at D=4, assert rst together with in_valid and cfg_depth = 2.
  - fill_count = 0, out = 0, D = 2; the concurrent sample is dropped.
  - The next 2 advances produce the first out_valid.
- Depth clamping:
  - cfg_depth = 0 at reset gives D = 1 and cfg_err = 1.
  - A clear with cfg_depth = 20 (MAX_DEPTH = 16) gives D = 16 and cfg_err = 1.
  - A clear with cfg_depth = 5 gives cfg_err = 0.
  - Changing cfg_depth without a clear leaves D and cfg_err unchanged.
- Maximum depth: D = 16 with 40 advances of an incrementing pattern (lane k = n + k).
  - out_valid first asserts after advance 16; each output equals the input from 16 advances earlier.
  - fill_count holds at 16.
- Reset priority: global_rst_n low together with rst, ce and in_valid high for one cycle mid-stream.
  - All outputs return to reset values the next cycle; no out_valid pulse.
